// File: rtl/seq_detector_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
package seq_detector_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_1     = 3'd1,
    S_10    = 3'd2,
    S_101   = 3'd3,
    S_MATCH = 3'd4
  } state_t;

  localparam logic [3:0] PATTERN     = 4'b1011;
  localparam int         PATTERN_LEN = 4;

endpackage

// File: rtl/seq_detector_if.sv
// Serial line bundle for seq_detector; match_count exists only when SEQ_DET_COUNT_EN is defined.
interface seq_detector_if #(
  parameter int COUNT_W = 8
);
  logic data_in;
  logic detected;
`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] match_count;

  modport master (output data_in, input  detected, input  match_count);
  modport slave  (input  data_in, output detected, output match_count);
`else
  // Width is accepted for build compatibility but has nothing to size here.
  if (COUNT_W < 1) begin : g_count_w_unused
  end

  modport master (output data_in, input  detected);
  modport slave  (input  data_in, output detected);
`endif
endinterface

// File: rtl/seq_detector_cnt.sv
// Saturating match counter, cleared only by the asynchronous reset.
module seq_detector_cnt #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_inc,
  output logic [COUNT_W-1:0] o_count
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  logic [COUNT_W-1:0] r_count;

  // Count register: hold at all-ones once reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= {COUNT_W{1'b0}};
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + COUNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detector.sv
// Overlapping 1011 serial pattern detector (Moore FSM, one-cycle registered flag).
// Optional saturating match counter enabled by SEQ_DET_COUNT_EN.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  seq_detector_if.slave bus
);

  state_t r_state;
  state_t w_next;
  logic   r_detected;

  // State register plus a registered copy of the S_MATCH decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_detected <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_detected <= (w_next == S_MATCH);
    end
  end

  // Each prefix state waits for the next pattern bit, MSB first.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = (bus.data_in == PATTERN[PATTERN_LEN-1]) ? S_1     : S_IDLE;
      S_1:     w_next = (bus.data_in == PATTERN[PATTERN_LEN-2]) ? S_10    : S_1;
      S_10:    w_next = (bus.data_in == PATTERN[PATTERN_LEN-3]) ? S_101   : S_IDLE;
      S_101:   w_next = (bus.data_in == PATTERN[PATTERN_LEN-4]) ? S_MATCH : S_10;
      S_MATCH: w_next = bus.data_in ? S_1 : S_10;
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.detected = r_detected;

`ifdef SEQ_DET_COUNT_EN
  logic               w_inc;
  logic [COUNT_W-1:0] w_count;

  assign w_inc = (w_next == S_MATCH);

  seq_detector_cnt #(
    .COUNT_W (COUNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_inc),
    .o_count (w_count)
  );

  assign bus.match_count = w_count;
`else
  if (COUNT_W < 1) begin : g_count_w_unused
  end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: driver queues hand-computed expectations, monitor checks each cycle.
module tb_seq_detector;

  localparam int CW = 2;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef struct {
    logic          det;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t q[$];
  logic [CW-1:0] mcnt;
  int n_vec;
  int n_err;

  seq_detector_if #(.COUNT_W(CW)) bus ();

  seq_detector #(.COUNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per rising edge, sampled 1 time unit later.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (bus.detected !== e.det) begin
          n_err++;
          $display("FAIL detected: got %0b want %0b at %0t", bus.detected, e.det, $time);
        end
`ifdef SEQ_DET_COUNT_EN
        n_vec++;
        if (bus.match_count !== e.cnt) begin
          n_err++;
          $display("FAIL match_count: got %0d want %0d at %0t", bus.match_count, e.cnt, $time);
        end
`endif
      end
    end
  end

  task automatic step(input logic din, input logic det, input logic rn);
    @(negedge clk);
    reset_n     = rn;
    bus.data_in = din;
    if (!rn) mcnt = '0;
    else if (det && (mcnt != CMAX)) mcnt = mcnt + CW'(1);
    q.push_back('{det, mcnt});
  endtask

  task automatic run(input string bits, input string dets);
    for (int i = 0; i < bits.len(); i++)
      step(bits[i] == 8'h31, dets[i] == 8'h31, 1'b1);
  endtask

  // Drop reset between edges and check the asynchronous clear immediately.
  task automatic rst_mid();
    @(negedge clk);
    #2;
    reset_n     = 1'b0;
    bus.data_in = 1'b1;
    #1;
    n_vec++;
    if (bus.detected !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst_det: got %0b want 0 at %0t", bus.detected, $time);
    end
`ifdef SEQ_DET_COUNT_EN
    n_vec++;
    if (bus.match_count !== {CW{1'b0}}) begin
      n_err++;
      $display("FAIL async_rst_cnt: got %0d want 0 at %0t", bus.match_count, $time);
    end
`endif
    mcnt = '0;
    q.push_back('{1'b0, {CW{1'b0}}});
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    n_vec = 0;
    n_err = 0;
    mcnt = '0;
    reset_n = 1'b0;
    bus.data_in = 1'b0;

    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    run("1011", "0001");
    run("00", "00");
    run("1011011", "0001001");
    run("00", "00");
    run("101011", "000001");
    run("00", "00");
    run("1011011", "0001001");
    rst_mid();

    run("101", "000");
    rst_mid();
    run("11011", "00001");
    run("00", "00");

    rst_mid();
    for (int k = 0; k < 5; k++) run("1011", "0001");
    run("00", "00");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
